// File: rtl/bc_polinomio.sv
// Horner sequencer for S = ((A*x)+B)*x + C: drives the datapath selects/strobes,
// each arithmetic step held LATENCIA cycles. Optional abort via BC_POLINOMIO_ABORTAR_EN.
module bc_polinomio #(
  parameter int LATENCIA = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inicio,
  input  logic       abortar,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       LX,
  output logic       LH,
  output logic       LS,
  output logic       H,
  output logic       pronto,
  output logic       ocupado,
  output logic [2:0] estado_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CARGA = 3'd1,
    MUL1  = 3'd2,
    SOMA1 = 3'd3,
    MUL2  = 3'd4,
    SOMA2 = 3'd5,
    FIM   = 3'd6
  } estado_t;

  localparam logic [3:0] ULTIMO_PASSO = 4'(LATENCIA - 1);

  estado_t    estado_q, estado_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ultimo;

  assign ultimo   = (cnt_q == ULTIMO_PASSO);
  assign estado_o = estado_q;

`ifndef BC_POLINOMIO_ABORTAR_EN
  logic unused_abortar;
  assign unused_abortar = abortar;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= IDLE;
      cnt_q    <= 4'd0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
    end
  end

  // Counter restarts at zero on every state change, so each step sees 0..LATENCIA-1.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = 4'd0;
    case (estado_q)
      IDLE:  if (inicio) estado_d = CARGA;
      CARGA: estado_d = MUL1;
      MUL1:  if (ultimo) estado_d = SOMA1; else cnt_d = cnt_q + 4'd1;
      SOMA1: if (ultimo) estado_d = MUL2;  else cnt_d = cnt_q + 4'd1;
      MUL2:  if (ultimo) estado_d = SOMA2; else cnt_d = cnt_q + 4'd1;
      SOMA2: if (ultimo) estado_d = FIM;   else cnt_d = cnt_q + 4'd1;
      FIM:   estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
`ifdef BC_POLINOMIO_ABORTAR_EN
    if (abortar && (estado_q != IDLE)) begin
      estado_d = IDLE;
      cnt_d    = 4'd0;
    end
`endif
  end

  // Outputs depend only on registered state and counter.
  always_comb begin
    M0      = 2'b00;
    M1      = 2'b00;
    M2      = 2'b00;
    LX      = 1'b0;
    LH      = 1'b0;
    LS      = 1'b0;
    H       = 1'b0;
    pronto  = 1'b0;
    ocupado = (estado_q != IDLE);
    case (estado_q)
      CARGA: LX = 1'b1;
      MUL1: begin
        M0 = 2'b01; M1 = 2'b00; M2 = 2'b00; H = 1'b1; LH = ultimo;
      end
      SOMA1: begin
        M0 = 2'b10; M1 = 2'b11; M2 = 2'b01; H = 1'b0; LH = ultimo;
      end
      MUL2: begin
        M0 = 2'b00; M1 = 2'b11; M2 = 2'b00; H = 1'b1; LH = ultimo;
      end
      SOMA2: begin
        M0 = 2'b11; M1 = 2'b11; M2 = 2'b01; H = 1'b0; LS = ultimo;
      end
      FIM: pronto = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bc_polinomio.sv
// Bench for bc_polinomio: a LATENCIA=4 instance wired to a behavioural datapath
// and a LATENCIA=1 instance, both compared cycle by cycle against a schedule model.
module tb_bc_polinomio;

  localparam int L4 = 4;
  localparam int L1 = 1;

  logic clk = 1'b0;
  logic rst, inicio4, inicio1, abortar;

  logic [1:0] m0_4, m1_4, m2_4, m0_1, m1_1, m2_1;
  logic lx_4, lh_4, ls_4, h_4, pr_4, oc_4;
  logic lx_1, lh_1, ls_1, h_1, pr_1, oc_1;
  logic [2:0] est_4, est_1;
  logic [11:0] obs4, obs1;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];
  bit mon_en = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  bc_polinomio #(.LATENCIA(L4)) dut4 (
    .clk(clk), .rst(rst), .inicio(inicio4), .abortar(abortar),
    .M0(m0_4), .M1(m1_4), .M2(m2_4), .LX(lx_4), .LH(lh_4), .LS(ls_4),
    .H(h_4), .pronto(pr_4), .ocupado(oc_4), .estado_o(est_4)
  );

  bc_polinomio #(.LATENCIA(L1)) dut1 (
    .clk(clk), .rst(rst), .inicio(inicio1), .abortar(abortar),
    .M0(m0_1), .M1(m1_1), .M2(m2_1), .LX(lx_1), .LH(lh_1), .LS(ls_1),
    .H(h_1), .pronto(pr_1), .ocupado(oc_1), .estado_o(est_1)
  );

  // Packing: [11:10]M0 [9:8]M1 [7:6]M2 [5]LX [4]LH [3]LS [2]H [1]pronto [0]ocupado
  assign obs4 = {m0_4, m1_4, m2_4, lx_4, lh_4, ls_4, h_4, pr_4, oc_4};
  assign obs1 = {m0_1, m1_1, m2_1, lx_1, lh_1, ls_1, h_1, pr_1, oc_1};

  // ---------------- datapath around dut4 ----------------
  logic [15:0] a_v, b_v, c_v, x_v, r0, r1, r2, m0_out, p1, p2, ula;

  always_comb begin
    case (m0_4)
      2'b00: m0_out = 16'd0;
      2'b01: m0_out = a_v;
      2'b10: m0_out = b_v;
      default: m0_out = c_v;
    endcase
    case (m1_4)
      2'b00: p1 = m0_out;
      2'b01: p1 = r0;
      2'b10: p1 = r2;
      default: p1 = r1;
    endcase
    case (m2_4)
      2'b00: p2 = r0;
      2'b01: p2 = m0_out;
      2'b10: p2 = r2;
      default: p2 = r1;
    endcase
    ula = h_4 ? p1 * p2 : p1 + p2;
  end

  always @(posedge clk) begin
    if (lx_4) r0 <= x_v;
    if (lh_4) r1 <= ula;
    if (ls_4) r2 <= ula;
  end

  // ---------------- reference model ----------------
  // Expected controls k cycles after the edge that sampled inicio (k=1 is the load
  // cycle); k outside 1..4L+2 is idle.
  function automatic logic [11:0] model_ctrl(input int k, input int l);
    logic [1:0] m0, m1, m2;
    logic lx, lh, ls, h, pr, oc;
    int step;
    bit last;
    m0 = 2'b00; m1 = 2'b00; m2 = 2'b00;
    lx = 0; lh = 0; ls = 0; h = 0; pr = 0; oc = 0;
    if (k >= 1 && k <= 4 * l + 2) begin
      oc = 1;
      if (k == 1) lx = 1;
      else if (k == 4 * l + 2) pr = 1;
      else begin
        step = (k - 2) / l;
        last = ((k - 2) % l) == (l - 1);
        case (step)
          0: begin m0 = 2'b01; m1 = 2'b00; m2 = 2'b00; h = 1; lh = last; end
          1: begin m0 = 2'b10; m1 = 2'b11; m2 = 2'b01; h = 0; lh = last; end
          2: begin m0 = 2'b00; m1 = 2'b11; m2 = 2'b00; h = 1; lh = last; end
          default: begin m0 = 2'b11; m1 = 2'b11; m2 = 2'b01; h = 0; ls = last; end
        endcase
      end
    end
    return {m0, m1, m2, lx, lh, ls, h, pr, oc};
  endfunction

  function automatic logic [15:0] horner(input logic [15:0] a, b, c, x);
    logic [15:0] s;
    s = a * x * x + b * x + c;
    return s;
  endfunction

  // ---------------- strobe exclusivity monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ($countones({lx_4, lh_4, ls_4}) > 1 || $countones({lx_1, lh_1, ls_1}) > 1) begin
        failures++;
        $display("FAIL strobe_exclusive t=%0t got4=%b got1=%b required=at most one high",
                 $time, {lx_4, lh_4, ls_4}, {lx_1, lh_1, ls_1});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_obs(input int which, output logic [11:0] o);
    tick();
    o = (which == 1) ? obs1 : obs4;
  endtask

  task automatic start_op(input int which, output logic [11:0] o);
    if (which == 1) inicio1 = 1'b1; else inicio4 = 1'b1;
    step_obs(which, o);
    inicio1 = 1'b0;
    inicio4 = 1'b0;
  endtask

  task automatic load_operands(input logic [15:0] a, b, c, x);
    a_v = a; b_v = b; c_v = c; x_v = x;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; inicio4 = 1'b0; inicio1 = 1'b0; abortar = 1'b0;
    load_operands(16'd0, 16'd0, 16'd0, 16'd0);
    tick(); tick();
    checks++;
    if (obs4 !== 12'd0 || obs1 !== 12'd0) begin
      failures++;
      $display("FAIL reset_idle got4=%h got1=%h required=000", obs4, obs1);
    end
    inicio4 = 1'b1; inicio1 = 1'b1; abortar = 1'b1;
    tick();
    checks++;
    if (obs4 !== 12'd0 || obs1 !== 12'd0) begin
      failures++;
      $display("FAIL reset_overrides_inicio got4=%h got1=%h required=000", obs4, obs1);
    end
    rst = 1'b0; inicio4 = 1'b0; inicio1 = 1'b0; abortar = 1'b0;
    tick();
    mon_en = 1'b1;
  endtask

  task automatic test_single_ops();
    logic [11:0] o, e;
    logic [15:0] s_exp;
    int k;
    for (int op = 0; op < 5; op++) begin
      if (op == 0) load_operands(16'd2, 16'd3, 16'd1, 16'd2);
      else if (op == 1) load_operands(16'd1, 16'd0, 16'd0, 16'd7);
      else load_operands(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      s_exp = horner(a_v, b_v, c_v, x_v);
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        step_obs(0, o);
        checks++;
        if (o !== 12'd0) begin
          failures++;
          $display("FAIL single_idle_gap op=%0d got=%h required=000", op, o);
        end
      end
      for (int kk = 1; kk <= 4 * L4 + 3; kk++) exp_q.push_back(model_ctrl(kk, L4));
      start_op(0, o);
      k = 1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL single_ctrl op=%0d k=%0d got=%h required=%h", op, k, o, e);
        end
        if (e[1]) begin
          checks++;
          if (r2 !== s_exp) begin
            failures++;
            $display("FAIL single_result op=%0d got=%0d required=%0d", op, r2, s_exp);
          end
        end
        if (exp_q.size() > 0) step_obs(0, o);
        k++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] o, e;
    logic [15:0] s_exp;
    int p, prontos;
    p = 4 * L4 + 3;
    prontos = 0;
    load_operands(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    s_exp = horner(a_v, b_v, c_v, x_v);
    for (int i = 0; i < 3 * p; i++) exp_q.push_back(model_ctrl((i % p) + 1, L4));
    inicio4 = 1'b1;
    step_obs(0, o);
    for (int i = 0; i < 3 * p; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b_ctrl i=%0d got=%h required=%h", i, o, e);
      end
      if (o[1]) begin
        prontos++;
        checks++;
        if (r2 !== s_exp) begin
          failures++;
          $display("FAIL b2b_result i=%0d got=%0d required=%0d", i, r2, s_exp);
        end
      end
      if (i == 3 * p - 1) inicio4 = 1'b0;
      step_obs(0, o);
    end
    checks++;
    if (prontos != 3 || o !== 12'd0) begin
      failures++;
      $display("FAIL b2b_count pronto_pulses=%0d final=%h required=3 and 000", prontos, o);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] o, e;
    int rk;
    rk = L4 + 4;
    load_operands(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    start_op(0, o);
    for (int k = 1; k <= rk; k++) begin
      e = model_ctrl(k, L4);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rstmid_pre k=%0d got=%h required=%h", k, o, e);
      end
      if (k == rk) rst = 1'b1;
      step_obs(0, o);
    end
    rst = 1'b0;
    for (int k = 0; k < 4 * L4 + 4; k++) begin
      checks++;
      if (o !== 12'd0) begin
        failures++;
        $display("FAIL rstmid_idle c=%0d got=%h required=000", k, o);
      end
      step_obs(0, o);
    end
    start_op(0, o);
    for (int k = 1; k <= 4 * L4 + 3; k++) begin
      e = model_ctrl(k, L4);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rstmid_fresh k=%0d got=%h required=%h", k, o, e);
      end
      if (k < 4 * L4 + 3) step_obs(0, o);
    end
  endtask

  task automatic test_abort();
    logic [11:0] o, e;
    int ak, prontos;
    bit aborta;
`ifdef BC_POLINOMIO_ABORTAR_EN
    aborta = 1'b1;
`else
    aborta = 1'b0;
`endif
    ak = 2 * L4 + 3;
    prontos = 0;
    for (int k = 1; k <= 4 * L4 + 3; k++)
      exp_q.push_back((aborta && k > ak) ? 12'd0 : model_ctrl(k, L4));
    abortar = 1'b1;
    start_op(0, o);
    abortar = 1'b0;
    for (int k = 1; k <= 4 * L4 + 3; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL abort_ctrl k=%0d got=%h required=%h", k, o, e);
      end
      if (o[1]) prontos++;
      abortar = (k == ak) ? 1'b1 : 1'b0;
      if (k < 4 * L4 + 3) step_obs(0, o);
    end
    abortar = 1'b0;
    checks++;
    if (prontos != (aborta ? 0 : 1)) begin
      failures++;
      $display("FAIL abort_pronto got=%0d required=%0d", prontos, aborta ? 0 : 1);
    end
    step_obs(0, o);
  endtask

  task automatic test_latencia1();
    logic [11:0] o, e;
    for (int op = 0; op < 3; op++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        step_obs(1, o);
        checks++;
        if (o !== 12'd0) begin
          failures++;
          $display("FAIL lat1_idle op=%0d got=%h required=000", op, o);
        end
      end
      for (int k = 1; k <= 4 * L1 + 3; k++) exp_q.push_back(model_ctrl(k, L1));
      start_op(1, o);
      for (int k = 1; k <= 4 * L1 + 3; k++) begin
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL lat1_ctrl op=%0d k=%0d got=%h required=%h", op, k, o, e);
        end
        if (k < 4 * L1 + 3) step_obs(1, o);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_ops();
    test_back_to_back();
    test_reset_mid();
    test_abort();
    test_latencia1();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
